// File: rtl/iob_cache_mem_responder_pkg.sv
// Shared constants for the native-interface memory responder: FSM encodings, counter width, LFSR taps.
package iob_cache_mem_responder_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned LFSR_W = 8;

  // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/iob_cache_resp_ram.sv
// Single-port byte-enabled RAM with registered read; the read register resets, the array does not.
module iob_cache_resp_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes; untouched lanes keep their contents
  always_ff @(posedge clk_i) begin
    if (en) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (wstrb[k]) mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
      end
    end
  end

  // Read data only changes on a read access, so it holds across writes
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rdata <= '0;
    end else if (en && (wstrb == '0)) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/iob_cache_mem_responder.sv
// Memory responder: accepts one request in IDLE, waits LATENCY (+stall) cycles, pulses ack.
// Optional feature: define IOB_CACHE_MEM_RESP_STALL_EN to add LFSR-driven random stall cycles.
module iob_cache_mem_responder
  import iob_cache_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LATENCY   = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                req,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ack
);

  localparam int unsigned STRB_W = DATA_W / 8;

  if (LATENCY + 3 > 2 ** CNT_W - 1) begin : g_lat_chk
    $error("LATENCY plus maximum stall does not fit the wait counter");
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    load_c;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                accept_c;
  logic                ram_en_c;
  logic [ADDR_W-1:0]   ram_addr_c;
  logic [DATA_W-1:0]   ram_wdata_c;
  logic [STRB_W-1:0]   ram_wstrb_c;

  assign accept_c = (state_q == ST_IDLE) && req;

`ifdef IOB_CACHE_MEM_RESP_STALL_EN
  logic [LFSR_W-1:0] lfsr_q;

  // Stall uses the current LFSR value, which then steps once per accepted request
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)     lfsr_q <= LFSR_SEED;
    else if (accept_c) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign load_c = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign load_c      = CNT_W'(LATENCY);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d   = load_c;
          state_d = (load_c != '0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack     <= (state_d == ST_ACK);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept_c) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  // The RAM access lands on the edge that enters ACK; a zero-wait request uses the live inputs
  assign ram_en_c    = arst_n_i && (state_d == ST_ACK);
  assign ram_addr_c  = (state_q == ST_IDLE) ? addr  : addr_q;
  assign ram_wdata_c = (state_q == ST_IDLE) ? wdata : wdata_q;
  assign ram_wstrb_c = (state_q == ST_IDLE) ? wstrb : wstrb_q;

  iob_cache_resp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .en       (ram_en_c),
    .addr     (ram_addr_c),
    .wdata    (ram_wdata_c),
    .wstrb    (ram_wstrb_c),
    .rdata    (rdata)
  );

endmodule

// File: tb/tb_iob_cache_mem_responder.sv
// Directed bench for iob_cache_mem_responder: three instances (LATENCY 2, 0, 5) driven as an initiator.
module tb_iob_cache_mem_responder;
  import iob_cache_mem_responder_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk;
  logic          arst_n;
  logic          req   [3];
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] wdata [3];
  logic [SW-1:0] wstrb [3];
  logic [DW-1:0] rdata [3];
  logic          ack   [3];

  int checks   = 0;
  int failures = 0;

`ifdef IOB_CACHE_MEM_RESP_STALL_EN
  logic [7:0] mlfsr [3];
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  iob_cache_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2)) u_dut0 (
    .clk_i(clk), .arst_n_i(arst_n), .req(req[0]), .addr(addr[0]), .wdata(wdata[0]),
    .wstrb(wstrb[0]), .rdata(rdata[0]), .ack(ack[0]));
  iob_cache_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(0)) u_dut1 (
    .clk_i(clk), .arst_n_i(arst_n), .req(req[1]), .addr(addr[1]), .wdata(wdata[1]),
    .wstrb(wstrb[1]), .rdata(rdata[1]), .ack(ack[1]));
  iob_cache_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(5)) u_dut2 (
    .clk_i(clk), .arst_n_i(arst_n), .req(req[2]), .addr(addr[2]), .wdata(wdata[2]),
    .wstrb(wstrb[2]), .rdata(rdata[2]), .ack(ack[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      default: return 5;
    endcase
  endfunction

  task automatic model_reset();
`ifdef IOB_CACHE_MEM_RESP_STALL_EN
    for (int i = 0; i < 3; i++) mlfsr[i] = 8'hA5;
`endif
  endtask

  // One complete transaction; latency counts clock edges from the accepting edge to the ack edge
  task automatic txn(input int d, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [SW-1:0] ws, input bit glitch,
                     output logic [DW-1:0] rd, output int lat);
    int unsigned exp_lat;
    logic        got;
    exp_lat = lat_of(d) + 1;
`ifdef IOB_CACHE_MEM_RESP_STALL_EN
    exp_lat += 32'(mlfsr[d][1:0]);
    mlfsr[d] = {mlfsr[d][6:0], mlfsr[d][7] ^ mlfsr[d][5] ^ mlfsr[d][4] ^ mlfsr[d][3]};
`endif
    @(negedge clk);
    req[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      got = ack[d];
      if (glitch && lat == 1) begin
        addr[d] = ~a; wdata[d] = ~wd; wstrb[d] = ~ws;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    rd = rdata[d];
    @(negedge clk);
    req[d] = 1'b0; wstrb[d] = '0;
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(ack[d]), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] rd;
    int            lat;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    model_reset();
    arst_n = 1'b1;
    #2 arst_n = 1'b0;

    // T1: reset held with a pending write request on instance 0
    req[0] = 1'b1; wstrb[0] = 4'hF;
    repeat (5) begin
      @(posedge clk); #1;
      chk("rst_ack", 32'(ack[0]), 32'd0);
      chk("rst_rdata", rdata[0], 32'd0);
    end
    chk("rst_rdata_l0", rdata[1], 32'd0);
    chk("rst_rdata_l5", rdata[2], 32'd0);
    @(negedge clk);
    req[0] = 1'b0; wstrb[0] = '0; arst_n = 1'b1;
    txn(0, 10'd0, 32'd0, 4'hF, 1'b0, rd, lat);

    // T2: write i*3, read back; writes leave rdata untouched
    for (int i = 0; i < 5; i++) begin
      txn(0, 10'(i), 32'(i * 3), 4'hF, 1'b0, rd, lat);
      chk("wr_hold_rdata", rd, 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      txn(0, 10'(i), 32'hFFFF_FFFF, 4'h0, 1'b0, rd, lat);
      chk("rd_back", rd, 32'(i * 3));
    end

    // T3: partial byte strobes
    txn(0, 10'd7, 32'h1122_3344, 4'hF, 1'b0, rd, lat);
    txn(0, 10'd7, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, lat);
    chk("strb_wr_hold", rd, 32'd12);
    txn(0, 10'd7, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("strb_merge", rd, 32'h11BB_33DD);

    // T4: zero latency, then input changes during WAIT on LATENCY=5; top address wraps cleanly
    txn(1, 10'd1, 32'hCAFE_0001, 4'hF, 1'b0, rd, lat);
    txn(1, 10'd1, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("l0_read", rd, 32'hCAFE_0001);
    txn(2, 10'd10, 32'h0000_1234, 4'hF, 1'b0, rd, lat);
    txn(2, 10'h3F5, 32'h0000_5678, 4'hF, 1'b0, rd, lat);
    txn(2, 10'd10, 32'h0, 4'h0, 1'b1, rd, lat);
    chk("latched_addr", rd, 32'h0000_1234);
    txn(2, 10'h3F5, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("no_glitch_write", rd, 32'h0000_5678);
    txn(1, 10'h3FF, 32'h5A5A_A5A5, 4'hF, 1'b0, rd, lat);
    txn(1, 10'h3FF, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("top_addr", rd, 32'h5A5A_A5A5);

    // T5: reset while a write waits; storage must be untouched
    @(negedge clk);
    req[0] = 1'b1; addr[0] = 10'd3; wdata[0] = 32'hDEAD_BEEF; wstrb[0] = 4'hF;
    @(posedge clk); #1;
    arst_n = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      chk("midop_ack", 32'(ack[0]), 32'd0);
    end
    @(negedge clk);
    req[0] = 1'b0; wstrb[0] = '0; arst_n = 1'b1;
    chk("midop_rdata_rst", rdata[0], 32'd0);
    txn(0, 10'd3, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("midop_mem_kept", rd, 32'd9);

`ifdef IOB_CACHE_MEM_RESP_STALL_EN
    // T6: stall latencies stay in range and follow the reference LFSR (exact value checked in txn)
    for (int i = 0; i < 16; i++) begin
      txn(0, 10'(i % 5), 32'h0, 4'h0, 1'b0, rd, lat);
      chk("stall_range", 32'(lat >= 3 && lat <= 6), 32'd1);
      chk("stall_rdata", rd, 32'((i % 5) * 3));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
